pixie_video_back_end: RTL
=========================

PIXIE_VIDEO_BACK_END -- requirements
Module: pixie_video_back_end

Interface
REQ-001 SHALL have parameter BYTES_PER_LINE, default 14, line length in bytes; 8 pixels per byte.
REQ-002 SHALL have parameter LINES_PER_FRAME, default 262, total lines per frame.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pix_ce, input, 1 bit: pixel clock enable; never asserted on two consecutive clk cycles.
REQ-006 SHALL have port mem_addr, output, 10 bits: frame-buffer read address.
REQ-007 SHALL have port mem_rd_en, output, 1 bit: read strobe, one clk wide.
REQ-008 SHALL have port mem_data, input, 8 bits: read data, valid exactly 1 clk after mem_rd_en.
REQ-009 SHALL have port video, output, 1 bit: serialized pixel, MSB of each byte first.
REQ-010 SHALL have ports hsync, vsync, hblank and vblank, outputs, 1 bit each, all active-high.

Function
REQ-011 SHALL keep h_cnt at 0..111 and v_cnt at 0..261, both advancing only on pix_ce; h_cnt wraps 111->0 and increments v_cnt; v_cnt wraps 261->0 on that same pix_ce.
REQ-012 SHALL define active lines as v_cnt 80..207 and active pixels as h_cnt 16..79, giving 64x128 pixels.
REQ-013 SHALL register hblank=(h_cnt<16 or h_cnt>79), vblank=(v_cnt<80 or v_cnt>207), hsync=(h_cnt 96..103) and vsync=(v_cnt 0..3) on each pix_ce from the pre-increment counters.
REQ-014 SHALL issue a fetch on pix_ce when the line is active and h_cnt is 15, 23, 31, ..., 71: mem_rd_en=1 for that clk, mem_addr={row[6:0], col[2:0]}, col=(h_cnt-15)>>3, row=v_cnt-80.
REQ-015 SHALL capture mem_data into a hold register on the clk after mem_rd_en.
REQ-016 SHALL, on pix_ce at an active pixel with h_cnt[2:0]==0, drive video<=hold[7] and load the shifter with {hold[6:0],0}.
REQ-017 SHALL, on any other active pix_ce, drive video<=shifter[7] and shift the shifter left by 1.
REQ-018 SHALL drive video<=0 on pix_ce outside the active area.
REQ-019 SHALL align video with hblank/vblank: both come from the same pix_ce and the same counter value.
REQ-020 SHALL hold every output and all state when pix_ce=0, except for the hold-register capture.
REQ-021 SHALL issue exactly 8 fetches per active line and 1024 per frame; addresses run 0..1023 in order with no gaps or repeats.

Reset
REQ-022 SHALL, while reset=1, clear h_cnt, v_cnt, the shifter, the hold register, video, mem_rd_en, mem_addr, hsync and vsync, and set hblank=1 and vblank=1.
REQ-023 SHALL let reset override pix_ce; reset asserted mid-line or mid-fetch discards the pending read, and the frame restarts at h_cnt=0, v_cnt=0.

Configuration
REQ-024 SHALL support macro PIXIE_LINE_REPEAT_EN: when defined, row=(v_cnt-80)>>1, each row is shown on two lines, and addresses span 0..511; when undefined, REQ-014 applies unchanged.

Structure
REQ-025 SHALL place the timing constants (active bounds 16/79 and 80/207, sync bounds 96..103 and 0..3, 8 pixels per byte) in shared package pixie_pkg, which the DMA front end also uses.
REQ-026 SHALL implement the counters and sync/blank generation in sub-module pixie_video_timing; fetch and serializer logic stay in the top module.

Verification
REQ-027 SHALL verify that after reset, with pix_ce every 2nd clk, the first mem_rd_en occurs at v_cnt=80, h_cnt=15 with mem_addr=0, and the last in the frame at v_cnt=207, h_cnt=71 with mem_addr=1023.
REQ-028 SHALL verify that with mem_data=0xA5 at address 0, video over h_cnt 16..23 on line 80 is 1,0,1,0,0,1,0,1, with hblank=0 throughout.
REQ-029 SHALL verify that across one full frame hsync pulses 262 times, each 8 pix_ce wide; vsync is high for 4 lines; video is 0 whenever hblank or vblank is 1.
REQ-030 SHALL verify that reset asserted at v_cnt=100, h_cnt=40 gives no mem_rd_en on the next clk, all counters at 0, and a next fetch of address 0 at v_cnt=80.
REQ-031 SHALL verify that with PIXIE_LINE_REPEAT_EN defined, lines 80 and 81 both fetch addresses 0..7, and line 207 fetches 504..511.
REQ-032 SHALL verify that with pix_ce held low for 1000 clk mid-line, all outputs and counters are frozen and no mem_rd_en occurs.

Source files
------------

// File: rtl/pixie_pkg.sv
// Shared Pixie display timing constants, used by the back end and the DMA front end.
// The PIXIE_LINE_REPEAT_EN option does not change these constants.
package pixie_pkg;

  localparam int PIX_PER_BYTE = 8;

  localparam logic [6:0] H_ACT_FIRST = 7'd16;
  localparam logic [6:0] H_ACT_LAST  = 7'd79;
  localparam logic [8:0] V_ACT_FIRST = 9'd80;
  localparam logic [8:0] V_ACT_LAST  = 9'd207;

  localparam logic [6:0] HS_FIRST = 7'd96;
  localparam logic [6:0] HS_LAST  = 7'd103;
  localparam logic [8:0] VS_FIRST = 9'd0;
  localparam logic [8:0] VS_LAST  = 9'd3;

  // a byte is fetched one pixel before its first pixel is shown
  localparam logic [6:0] FETCH_LEAD = 7'd1;

  function automatic logic h_in(
    input logic [6:0] x,
    input logic [6:0] lo,
    input logic [6:0] hi
  );
    return (x >= lo) && (x <= hi);
  endfunction

  function automatic logic v_in(
    input logic [8:0] x,
    input logic [8:0] lo,
    input logic [8:0] hi
  );
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/pixie_video_timing.sv
// Pixie raster counters and registered sync/blank generation.
// Not affected by the PIXIE_LINE_REPEAT_EN option.
module pixie_video_timing
  import pixie_pkg::*;
#(
  parameter int BYTES_PER_LINE  = 14,
  parameter int LINES_PER_FRAME = 262
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pix_ce,
  output logic [6:0] o_h_cnt,
  output logic [8:0] o_v_cnt,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_hblank,
  output logic       o_vblank
);

  localparam logic [6:0] H_LAST =
    7'(BYTES_PER_LINE * PIX_PER_BYTE - 1);
  localparam logic [8:0] V_LAST =
    9'(LINES_PER_FRAME - 1);

  logic [6:0] r_h;
  logic [8:0] r_v;
  logic       r_hs;
  logic       r_vs;
  logic       r_hb;
  logic       r_vb;

  // advance raster and register sync/blank from pre-increment counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h  <= '0;
      r_v  <= '0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
      r_hb <= 1'b1;
      r_vb <= 1'b1;
    end else if (i_pix_ce) begin
      r_hb <= !h_in(r_h, H_ACT_FIRST, H_ACT_LAST);
      r_vb <= !v_in(r_v, V_ACT_FIRST, V_ACT_LAST);
      r_hs <= h_in(r_h, HS_FIRST, HS_LAST);
      r_vs <= v_in(r_v, VS_FIRST, VS_LAST);
      if (r_h == H_LAST) begin
        r_h <= '0;
        if (r_v == V_LAST) r_v <= '0;
        else               r_v <= r_v + 9'd1;
      end else begin
        r_h <= r_h + 7'd1;
      end
    end
  end

  assign o_h_cnt  = r_h;
  assign o_v_cnt  = r_v;
  assign o_hsync  = r_hs;
  assign o_vsync  = r_vs;
  assign o_hblank = r_hb;
  assign o_vblank = r_vb;

endmodule

// File: rtl/pixie_video_back_end.sv
// Pixie video back end: frame-buffer fetch and 1bpp serializer.
// Option PIXIE_LINE_REPEAT_EN shows each stored row on two lines.
module pixie_video_back_end
  import pixie_pkg::*;
#(
  parameter int BYTES_PER_LINE  = 14,
  parameter int LINES_PER_FRAME = 262
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  output logic [9:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_data,
  output logic       video,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank
);

  logic [6:0] w_h;
  logic [8:0] w_v;
  logic       w_line_act;
  logic       w_pix_act;
  logic       w_byte_start;
  logic       w_pix_shift;
  logic       w_fetch;
  logic [6:0] w_hrel;
  logic [6:0] w_vrel;
  logic [6:0] w_row;
  logic [2:0] w_col;
  logic [7:0] w_byte;

  logic       r_rd_en;
  logic [9:0] r_addr;
  logic       r_rd_dly;
  logic [7:0] r_hold;
  logic [7:0] r_shift;
  logic       r_video;

  pixie_video_timing #(
    .BYTES_PER_LINE  (BYTES_PER_LINE),
    .LINES_PER_FRAME (LINES_PER_FRAME)
  ) u_timing (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_pix_ce (pix_ce),
    .o_h_cnt  (w_h),
    .o_v_cnt  (w_v),
    .o_hsync  (hsync),
    .o_vsync  (vsync),
    .o_hblank (hblank),
    .o_vblank (vblank)
  );

  assign w_line_act = v_in(w_v, V_ACT_FIRST, V_ACT_LAST);
  assign w_pix_act  = w_line_act
    && h_in(w_h, H_ACT_FIRST, H_ACT_LAST);
  assign w_byte_start = w_pix_act && (w_h[2:0] == 3'd0);
  assign w_pix_shift  = w_pix_act && (w_h[2:0] != 3'd0);

  assign w_fetch = pix_ce && w_line_act
    && h_in(w_h, H_ACT_FIRST - FETCH_LEAD,
            H_ACT_LAST - 7'(PIX_PER_BYTE))
    && (w_h[2:0] == 3'(PIX_PER_BYTE - 1));

  assign w_hrel = w_h - (H_ACT_FIRST - FETCH_LEAD);
  assign w_col  = 3'(w_hrel >> 3);
  assign w_vrel = w_v[6:0] - V_ACT_FIRST[6:0];

`ifdef PIXIE_LINE_REPEAT_EN
  assign w_row = w_vrel >> 1;
`else
  assign w_row = w_vrel;
`endif

  // the byte lands in the same clk as the first pixel: forward it
  assign w_byte = r_rd_dly ? mem_data : r_hold;

  // issue one-clk read strobe and latch its address
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_rd_en <= w_fetch;
      if (w_fetch) r_addr <= {w_row, w_col};
    end
  end

  // capture read data one clk after the strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_dly <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_rd_dly <= r_rd_en;
      if (r_rd_dly) r_hold <= mem_data;
    end
  end

  // serialize MSB first, blank outside the active area
  always_ff @(posedge clk) begin
    if (reset) begin
      r_video <= 1'b0;
      r_shift <= '0;
    end else if (pix_ce) begin
      unique case (1'b1)
        w_byte_start: begin
          r_video <= w_byte[7];
          r_shift <= {w_byte[6:0], 1'b0};
        end
        w_pix_shift: begin
          r_video <= r_shift[7];
          r_shift <= {r_shift[6:0], 1'b0};
        end
        default: r_video <= 1'b0;
      endcase
    end
  end

  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_addr;
  assign video     = r_video;

endmodule
